// File: rtl/pc_pkg.sv
// Shared types for the PC sequencer.
//   pc_src_e   : next-PC select encoding driven by the decoder.
//   pc_state_e : sequencer FSM states.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_TRAP   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    BOOT     = 2'b00,
    RUN      = 2'b01,
    REDIRECT = 2'b10
  } pc_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/result bundle between the decode stage and the PC sequencer.
//   master : decode side, drives stall/pc_src/imm/rs1/is_call/is_ret,
//            observes pc/pc_plus4/fetch_valid/misalign_err.
//   slave  : sequencer side, the mirror image.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  import pc_pkg::*;

  logic             stall;
  pc_src_e          pc_src;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] rs1;
  logic             is_call;
  logic             is_ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             fetch_valid;
  logic             misalign_err;

  modport master (
    output stall, pc_src, imm, rs1, is_call, is_ret,
    input  pc, pc_plus4, fetch_valid, misalign_err
  );

  modport slave (
    input  stall, pc_src, imm, rs1, is_call, is_ret,
    output pc, pc_plus4, fetch_valid, misalign_err
  );

endinterface

// File: rtl/pc_ras.sv
// Return-address stack as a circular buffer.
//   clk, rst  : clock, async active-low reset (clears pointer and count only)
//   push      : write push_data as the new top
//   pop       : discard top (ignored while empty)
//   push_data : return address to store
//   top       : current top entry
//   empty     : no valid entries
//   full      : DEPTH valid entries
// Pushing while full overwrites the oldest entry; count saturates at DEPTH.
// Push and pop together replace the top in place.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  ptr_q;     // next write slot
  logic [PtrW-1:0]  ptr_top;
  logic [PtrW:0]    count_q;
  logic             pop_eff;

  assign ptr_top = ptr_q - 1'b1;
  assign top     = mem_q[ptr_top];
  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign pop_eff = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push && !pop_eff) begin
      ptr_q <= ptr_q + 1'b1;
      if (!full) count_q <= count_q + 1'b1;
    end else if (pop_eff && !push) begin
      ptr_q   <= ptr_top;
      count_q <= count_q - 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push && pop_eff) begin
      mem_q[ptr_top] <= push_data;
    end else if (push) begin
      mem_q[ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with BOOT/RUN/REDIRECT control.
//   clk, rst : clock, async active-low reset
//   bus      : pc_sequencer_if.slave (stall, pc_src, imm, rs1, is_call, is_ret in;
//              pc, pc_plus4, fetch_valid, misalign_err out)
// Optional feature: define PC_SEQUENCER_RAS_EN to build in the return-address
// stack (pc_ras); otherwise is_call/is_ret are ignored and JALR uses rs1+imm.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  pc_sequencer_if.slave    bus
);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("RAS_DEPTH must be a power of two and at least 2");
  end

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] jalr_tgt;
  logic [WIDTH-1:0] target;
  logic             active;
  logic             misalign;

  assign pc_plus4 = pc_q + WIDTH'(4);
  assign jalr_sum = bus.rs1 + bus.imm;
  assign active   = (state_q == RUN) && !bus.stall;
  assign misalign = active && (target[1:0] != 2'b00);

`ifdef PC_SEQUENCER_RAS_EN
  logic             call_req, ret_req;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full_unused;

  // A trap select suppresses both; a misaligned target leaves the stack intact.
  assign call_req = active && bus.is_call &&
                    (bus.pc_src == PC_BRANCH || bus.pc_src == PC_JALR);
  assign ret_req  = active && bus.is_ret && (bus.pc_src == PC_JALR);
  assign jalr_tgt = (ret_req && !ras_empty) ? ras_top : {jalr_sum[WIDTH-1:1], 1'b0};

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (call_req && !misalign),
    .pop       (ret_req && !misalign),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full_unused)
  );
`else
  logic unused_ras;

  assign unused_ras = bus.is_call ^ bus.is_ret;
  assign jalr_tgt   = {jalr_sum[WIDTH-1:1], 1'b0};
`endif

  always_comb begin
    target = TRAP_VEC;
    unique case (bus.pc_src)
      PC_INC:    target = pc_plus4;
      PC_BRANCH: target = pc_q + bus.imm;
      PC_JALR:   target = jalr_tgt;
      default:   target = TRAP_VEC;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      BOOT: begin
        pc_d    = RESET_PC;
        state_d = RUN;
      end
      RUN: begin
        if (!bus.stall) begin
          if (misalign) begin
            pc_d    = TRAP_VEC;
            state_d = REDIRECT;
          end else begin
            pc_d = target;
          end
        end
      end
      REDIRECT: state_d = RUN;
      default:  state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.fetch_valid  = (state_q == RUN);
  assign bus.misalign_err = misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (WIDTH=32, RESET_PC=0, TRAP_VEC=0x100, RAS_DEPTH=4).
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(WIDTH)) bus ();

  pc_sequencer #(
    .WIDTH     (WIDTH),
    .RESET_PC  (32'h0000_0000),
    .TRAP_VEC  (32'h0000_0100),
    .RAS_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input pc_src_e src, input logic [31:0] imm, input logic [31:0] rs1,
                       input logic call, input logic ret, input logic stall);
    bus.pc_src  = src;
    bus.imm     = imm;
    bus.rs1     = rs1;
    bus.is_call = call;
    bus.is_ret  = ret;
    bus.stall   = stall;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pc(input string tag, input logic [31:0] pc, input logic fv);
    check({tag, ".pc"}, bus.pc, pc);
    check({tag, ".fv"}, 32'(bus.fetch_valid), 32'(fv));
  endtask

  logic [31:0] ret_exp [5];

  initial begin
`ifdef PC_SEQUENCER_RAS_EN
    ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h900};
`else
    ret_exp = '{32'h900, 32'h900, 32'h900, 32'h900, 32'h900};
`endif
    rst = 1'b0;
    drive(PC_INC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #12;
    check_pc("rst", 32'h0, 1'b0);
    check("rst.mis", 32'(bus.misalign_err), 32'h0);
    rst = 1'b1;
    #1;
    check_pc("boot", 32'h0, 1'b0);

    // Sequential fetch after release: 0, 4, 8, 12
    step(); check_pc("inc0", 32'h0, 1'b1);
    step(); check_pc("inc1", 32'h4, 1'b1);
    step(); check_pc("inc2", 32'h8, 1'b1);
    step(); check_pc("inc3", 32'hC, 1'b1);
    check("inc3.p4", bus.pc_plus4, 32'h10);

    // Branch to 0x40, then back by 8, then stall three cycles
    drive(PC_BRANCH, 32'h34, 32'h0, 1'b0, 1'b0, 1'b0);
    step(); check_pc("br40", 32'h40, 1'b1);
    drive(PC_BRANCH, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0, 1'b0);
    step(); check_pc("br38", 32'h38, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_pc($sformatf("stall%0d", i), 32'h38, 1'b1);
    end

    // JALR to 0x1003 -> 0x1002, misaligned: pulse, trap, one-cycle bubble
    drive(PC_JALR, 32'h0, 32'h1003, 1'b0, 1'b0, 1'b0);
    #1; check("jalr.mis", 32'(bus.misalign_err), 32'h1);
    step(); check_pc("redir", 32'h100, 1'b0);
    check("redir.mis", 32'(bus.misalign_err), 32'h0);
    drive(PC_INC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);  // stall ignored in REDIRECT
    step(); check_pc("redir_out", 32'h100, 1'b1);
    step(); check_pc("run_stall", 32'h100, 1'b1);
    bus.stall = 1'b0;
    step(); check_pc("run_inc", 32'h104, 1'b1);

    // Misaligned branch with is_call must not push
    drive(PC_BRANCH, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0);
    #1; check("brmis.mis", 32'(bus.misalign_err), 32'h1);
    step(); check_pc("brmis", 32'h100, 1'b0);
    drive(PC_INC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(); check_pc("brmis_out", 32'h100, 1'b1);
    step(); check_pc("inc104", 32'h104, 1'b1);

    // Trap overrides is_call; no redirect bubble
    drive(PC_TRAP, 32'h8, 32'h0, 1'b1, 1'b1, 1'b0);
    #1; check("trap.mis", 32'(bus.misalign_err), 32'h0);
    step(); check_pc("trap", 32'h100, 1'b1);

    // Return with empty stack falls back to rs1+imm
    drive(PC_JALR, 32'h0, 32'h10, 1'b0, 1'b1, 1'b0);
    step(); check_pc("ret_empty", 32'h10, 1'b1);

    // Five calls from 0x10..0x50, then five returns
    for (int i = 0; i < 5; i++) begin
      drive(PC_BRANCH, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
      step(); check_pc($sformatf("call%0d", i), 32'h20 + 32'h10 * i, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      drive(PC_JALR, 32'h0, 32'h900, 1'b0, 1'b1, 1'b0);
      step(); check_pc($sformatf("ret%0d", i), ret_exp[i], 1'b1);
    end

    // Call+ret in one cycle replaces the top
    drive(PC_BRANCH, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0);
    step(); check_pc("call_a00", 32'hA00, 1'b1);
    drive(PC_JALR, 32'h0, 32'h900, 1'b1, 1'b1, 1'b0);
    step();
`ifdef PC_SEQUENCER_RAS_EN
    check_pc("callret", 32'h904, 1'b1);
`else
    check_pc("callret", 32'h900, 1'b1);
`endif
    drive(PC_JALR, 32'h0, 32'h200, 1'b0, 1'b1, 1'b0);
    step();
`ifdef PC_SEQUENCER_RAS_EN
    check_pc("ret_repl", 32'hA04, 1'b1);
`else
    check_pc("ret_repl", 32'h200, 1'b1);
`endif
    step(); check_pc("ret_drain", 32'h200, 1'b1);

    // Wrap-around at the top of the address space
    drive(PC_BRANCH, 32'hFFFF_FDFC, 32'h0, 1'b0, 1'b0, 1'b0);
    step(); check_pc("top", 32'hFFFF_FFFC, 1'b1);
    check("top.p4", bus.pc_plus4, 32'h0);
    drive(PC_INC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(); check_pc("wrap", 32'h0, 1'b1);

    // Fill one RAS entry, stall, then reset mid-stall
    drive(PC_BRANCH, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
    step(); check_pc("pre_call", 32'h40, 1'b1);
    drive(PC_JALR, 32'h0, 32'h300, 1'b0, 1'b1, 1'b1);
    step(); check_pc("pre_stall", 32'h40, 1'b1);
    #2 rst = 1'b0;
    #1; check_pc("mid_rst", 32'h0, 1'b0);
    check("mid_rst.mis", 32'(bus.misalign_err), 32'h0);
    #2 rst = 1'b1;
    #1; check_pc("mid_boot", 32'h0, 1'b0);
    step(); check_pc("boot_run", 32'h0, 1'b1);  // stall and pc_src ignored in BOOT
    bus.stall = 1'b0;
    step(); check_pc("ret_after_rst", 32'h300, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
